// File: rtl/f1_lights_seq.sv
// F1 start-light sequencer: fills the lamp bar one lamp per tick, holds for an LFSR-randomised number of ticks, then goes dark.
// Define F1_REACTION_EN to build the reaction-time timer and jump-start detection.
module f1_lights_seq #(
    parameter int unsigned N_LIGHTS    = 8,
    parameter int unsigned TICK_CYCLES = 1000,
    parameter int unsigned MIN_HOLD    = 2,
    parameter int unsigned HOLD_RAND_W = 3,
    parameter int unsigned RT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trigger,
    input  logic                abort,
    input  logic                react,
    output logic [N_LIGHTS-1:0] lights,
    output logic                busy,
    output logic                go,
    output logic                rt_valid,
    output logic [RT_W-1:0]     reaction_time,
    output logic                jump_start
);
    localparam int unsigned     TC_W      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned     HC_W      = $clog2(MIN_HOLD + 256) + 1;
    localparam logic [15:0]     RAND_MASK = 16'((32'd1 << HOLD_RAND_W) - 32'd1);
    localparam logic [TC_W-1:0] TICK_LAST = TC_W'(TICK_CYCLES - 1);

`ifdef F1_REACTION_EN
    typedef enum logic [1:0] {IDLE, FILL, HOLD, TIMING} state_t;
`else
    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
`endif

    state_t              state_q, state_d;
    logic [TC_W-1:0]     tick_q, tick_d;
    logic [HC_W-1:0]     hold_q, hold_d;
    logic [N_LIGHTS-1:0] lights_q, lights_d;
    logic                busy_q;
    logic                go_q, go_d;
    logic                rtv_q, rtv_d;
    logic                js_q, js_d;
    logic [RT_W-1:0]     rt_q, rt_d;
    logic [15:0]         lfsr_q;
    logic                tick_end_c;
    logic [HC_W-1:0]     hold_load_c;
`ifdef F1_REACTION_EN
    logic [RT_W-1:0]     rtc_q, rtc_d;
`else
    logic                unused_react;
    assign unused_react = react;
`endif

    assign tick_end_c  = (tick_q == TICK_LAST);
    assign hold_load_c = HC_W'(MIN_HOLD) + HC_W'(lfsr_q & RAND_MASK);

    // Next-state and registered-output decode; abort overrides everything
    always_comb begin
        state_d  = state_q;
        tick_d   = '0;
        hold_d   = hold_q;
        lights_d = lights_q;
        go_d     = 1'b0;
        rtv_d    = 1'b0;
        js_d     = 1'b0;
        rt_d     = rt_q;
`ifdef F1_REACTION_EN
        rtc_d    = rtc_q;
`endif
        if (abort) begin
            state_d  = IDLE;
            lights_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    lights_d = '0;
                    if (trigger) begin
                        state_d  = FILL;
                        lights_d = N_LIGHTS'(1);
                    end
                end
                FILL: begin
                    tick_d = tick_end_c ? '0 : tick_q + TC_W'(1);
                    if (tick_end_c) begin
                        if (&lights_q) begin
                            state_d = HOLD;
                            hold_d  = hold_load_c;
                        end else begin
                            lights_d = N_LIGHTS'({lights_q, 1'b1});
                        end
                    end
                end
                HOLD: begin
                    tick_d = tick_end_c ? '0 : tick_q + TC_W'(1);
                    if (tick_end_c) begin
                        hold_d = hold_q - HC_W'(1);
                        if (hold_q == HC_W'(1)) begin
                            lights_d = '0;
                            go_d     = 1'b1;
`ifdef F1_REACTION_EN
                            state_d  = TIMING;
                            rtc_d    = '0;
`else
                            state_d  = IDLE;
`endif
                        end
                    end
                end
`ifdef F1_REACTION_EN
                TIMING: begin
                    rtc_d = rtc_q + RT_W'(1);
                    if (react || (&rtc_q)) begin
                        rt_d    = rtc_q;
                        rtv_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
`endif
                default: begin
                    state_d  = IDLE;
                    lights_d = '0;
                end
            endcase
`ifdef F1_REACTION_EN
            // A press before lights-out, even on the final hold tick, cancels the start
            if (react && (state_q == FILL || state_q == HOLD)) begin
                state_d  = IDLE;
                lights_d = '0;
                go_d     = 1'b0;
                js_d     = 1'b1;
                tick_d   = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            hold_q   <= '0;
            lights_q <= '0;
            busy_q   <= 1'b0;
            go_q     <= 1'b0;
            rtv_q    <= 1'b0;
            js_q     <= 1'b0;
            rt_q     <= '0;
`ifdef F1_REACTION_EN
            rtc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            hold_q   <= hold_d;
            lights_q <= lights_d;
            busy_q   <= (state_d != IDLE);
            go_q     <= go_d;
            rtv_q    <= rtv_d;
            js_q     <= js_d;
            rt_q     <= rt_d;
`ifdef F1_REACTION_EN
            rtc_q    <= rtc_d;
`endif
        end
    end

    // 16-bit Fibonacci LFSR, taps 16,14,13,11, free-running in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    assign lights        = lights_q;
    assign busy          = busy_q;
    assign go            = go_q;
    assign rt_valid      = rtv_q;
    assign reaction_time = rt_q;
    assign jump_start    = js_q;

endmodule

// File: tb/tb_f1_lights_seq.sv
// Self-checking bench for f1_lights_seq: timeline model computed from tick/hold arithmetic, randomised react/abort/gaps.
module tb_f1_lights_seq;
    localparam int unsigned N  = 4;
    localparam int unsigned T  = 2;
    localparam int unsigned MH = 1;
    localparam int unsigned HW = 2;
    localparam int unsigned RW = 4;
    localparam int F       = N * T;
    localparam int RT_MAX  = (1 << RW) - 1;
    localparam int K_ABORT = 0;
    localparam int K_JUMP  = 1;
    localparam int K_REACT = 2;
    localparam int K_DONE  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trigger = 1'b0;
    logic          abort = 1'b0;
    logic          react = 1'b0;
    logic [N-1:0]  lights;
    logic          busy, go, rt_valid, jump_start;
    logic [RW-1:0] reaction_time;

    int checks = 0;
    int failures = 0;
    int adv = 0;
    int exp_rt = 0;

    f1_lights_seq #(
        .N_LIGHTS(N), .TICK_CYCLES(T), .MIN_HOLD(MH), .HOLD_RAND_W(HW), .RT_W(RW)
    ) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .abort(abort), .react(react),
        .lights(lights), .busy(busy), .go(go), .rt_valid(rt_valid),
        .reaction_time(reaction_time), .jump_start(jump_start)
    );

    always #5 clk = ~clk;

    // Number of LFSR advances since the last reset edge
    always @(posedge clk) adv <= rst ? 0 : adv + 1;

    function automatic logic [15:0] lfsr_after(input int n);
        logic [15:0] l;
        l = 16'hACE1;
        for (int i = 0; i < n; i++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        return l;
    endfunction

    // Trigger in cycle 0, then check every cycle against the expected timeline
    task automatic run_seq(input string name, input int r_in, input bit r_rel, input int a, input int tmid);
        int h, lout, stop, kind, rv, r, m, e_rt;
        logic [N-1:0] e_l;
        logic e_busy, e_go, e_rtv, e_js;
        @(negedge clk);
        h    = int'(MH) + int'(lfsr_after(adv + F) & 16'((1 << HW) - 1));
        lout = (int'(N) + h) * int'(T) + 1;
        r    = r_rel ? lout + r_in : r_in;
        rv   = 0;
`ifdef F1_REACTION_EN
        if (r >= 1 && r < lout) begin
            stop = r + 1; kind = K_JUMP;
        end else if (r >= lout && r <= lout + RT_MAX) begin
            stop = r + 1; kind = K_REACT; rv = r - lout;
        end else begin
            stop = lout + RT_MAX + 1; kind = K_REACT; rv = RT_MAX;
        end
`else
        stop = lout; kind = K_DONE;
`endif
        if (a >= 1 && a + 1 <= stop) begin
            stop = a + 1; kind = K_ABORT;
        end
        trigger = 1'b1; react = 1'b0; abort = 1'b0;
        for (int k = 1; k <= stop + 2; k++) begin
            @(negedge clk);
            e_rt = exp_rt; e_go = 1'b0; e_rtv = 1'b0; e_js = 1'b0; e_busy = 1'b0; e_l = '0;
            if (k < stop) begin
                e_busy = 1'b1;
                m = (k - 1) / int'(T) + 1;
                if (m > int'(N)) m = int'(N);
                if (k <= F) e_l = N'((1 << m) - 1);
                else if (k < lout) e_l = '1;
                e_go = (k == lout);
            end else if (k == stop) begin
                e_go  = (k == lout) && (kind == K_DONE);
                e_js  = (kind == K_JUMP);
                e_rtv = (kind == K_REACT);
                if (kind == K_REACT) begin
                    exp_rt = rv; e_rt = rv;
                end
            end
            checks += 6;
            if (lights !== e_l) begin failures++; $display("FAIL %s k=%0d lights got %b want %b", name, k, lights, e_l); end
            if (busy !== e_busy) begin failures++; $display("FAIL %s k=%0d busy got %b want %b", name, k, busy, e_busy); end
            if (go !== e_go) begin failures++; $display("FAIL %s k=%0d go got %b want %b", name, k, go, e_go); end
            if (rt_valid !== e_rtv) begin failures++; $display("FAIL %s k=%0d rt_valid got %b want %b", name, k, rt_valid, e_rtv); end
            if (jump_start !== e_js) begin failures++; $display("FAIL %s k=%0d jump_start got %b want %b", name, k, jump_start, e_js); end
            if (reaction_time !== RW'(e_rt)) begin failures++; $display("FAIL %s k=%0d reaction_time got %0d want %0d", name, k, reaction_time, e_rt); end
            trigger = (k == tmid) && (k < stop);
            react   = (k == r);
            abort   = (k == a);
        end
        trigger = 1'b0; react = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; trigger = 1'b0; abort = 1'b0; react = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_rt = 0;
        checks += 6;
        if (lights !== '0) begin failures++; $display("FAIL reset lights got %b want 0", lights); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset busy got %b want 0", busy); end
        if (go !== 1'b0) begin failures++; $display("FAIL reset go got %b want 0", go); end
        if (rt_valid !== 1'b0) begin failures++; $display("FAIL reset rt_valid got %b want 0", rt_valid); end
        if (jump_start !== 1'b0) begin failures++; $display("FAIL reset jump_start got %b want 0", jump_start); end
        if (reaction_time !== '0) begin failures++; $display("FAIL reset reaction_time got %0d want 0", reaction_time); end
    endtask

    task automatic test_basic();
        run_seq("basic", 0, 1'b0, 0, 0);
    endtask

    task automatic test_reaction();
        run_seq("reaction", 3, 1'b1, 0, 0);
        run_seq("react_on_go", 0, 1'b1, 0, 0);
    endtask

    task automatic test_jump();
        run_seq("jump_fill", 1, 1'b0, 0, 0);
        run_seq("jump_hold", F + 1, 1'b0, 0, 0);
        run_seq("jump_last_tick", -1, 1'b1, 0, 0);
    endtask

    task automatic test_abort();
        run_seq("abort_fill", 0, 1'b0, 4, 3);
        run_seq("abort_vs_jump", 6, 1'b0, 6, 0);
        run_seq("abort_timing", 5, 1'b1, 20, 0);
    endtask

    task automatic test_timeout();
        run_seq("timeout", RT_MAX, 1'b1, 0, 0);
        run_seq("timeout_late", RT_MAX + 2, 1'b1, 0, 0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk); trigger = 1'b1; abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_over_trigger busy got %b want 0", busy); end
        @(negedge clk); abort = 1'b1;
        checks += 2;
        if (lights !== N'(1)) begin failures++; $display("FAIL held_trigger_start lights got %b want 0001", lights); end
        if (busy !== 1'b1) begin failures++; $display("FAIL held_trigger_start busy got %b want 1", busy); end
        @(negedge clk); abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || lights !== '0) begin failures++; $display("FAIL abort_idle busy=%b lights=%b want 0/0", busy, lights); end
        @(negedge clk);
        checks++;
        if (lights !== N'(1) || busy !== 1'b1) begin failures++; $display("FAIL restart lights=%b busy=%b want 0001/1", lights, busy); end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (lights !== N'(3)) begin failures++; $display("FAIL trigger_in_fill lights got %b want 0011", lights); end
        trigger = 1'b0; abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || lights !== '0) begin failures++; $display("FAIL cleanup busy=%b lights=%b want 0/0", busy, lights); end
    endtask

    task automatic test_random();
        int ab, tm;
        for (int i = 0; i < 14; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 24)) : 0;
            tm = int'($urandom_range(0, 6));
            if ($urandom_range(0, 1) == 0) run_seq("rnd_rel", int'($urandom_range(0, 18)), 1'b1, ab, tm);
            else run_seq("rnd_abs", int'($urandom_range(0, 22)), 1'b0, ab, tm);
        end
    endtask

    task automatic test_reset_mid();
        run_seq("pre_reset_react", 5, 1'b1, 0, 0);
        @(negedge clk); trigger = 1'b1;
        @(negedge clk); trigger = 1'b0;
        repeat (F + 1) @(negedge clk);
        checks += 2;
        if (busy !== 1'b1) begin failures++; $display("FAIL hold_before_rst busy got %b want 1", busy); end
        if (lights !== '1) begin failures++; $display("FAIL hold_before_rst lights got %b want 1111", lights); end
        rst = 1'b1; react = 1'b1;
        @(negedge clk);
        rst = 1'b0; react = 1'b0;
        exp_rt = 0;
        checks += 6;
        if (lights !== '0) begin failures++; $display("FAIL rst_mid lights got %b want 0", lights); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid busy got %b want 0", busy); end
        if (go !== 1'b0) begin failures++; $display("FAIL rst_mid go got %b want 0", go); end
        if (rt_valid !== 1'b0) begin failures++; $display("FAIL rst_mid rt_valid got %b want 0", rt_valid); end
        if (jump_start !== 1'b0) begin failures++; $display("FAIL rst_mid jump_start got %b want 0", jump_start); end
        if (reaction_time !== '0) begin failures++; $display("FAIL rst_mid reaction_time got %0d want 0", reaction_time); end
        run_seq("after_reset", 2, 1'b1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reaction();
        test_jump();
        test_abort();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
